// File: rtl/systolic_array_sequencer_pkg.sv
// Shared definitions for the systolic-array pass sequencer: FSM states,
// operand-buffer latency and the wavefront drain length.
package systolic_array_sequencer_pkg;

    localparam int ARRAY_DIM_DEF = 4;
    localparam int K_WIDTH_DEF   = 8;

    // Extra cycles after the last operand read until the far corner PE is final.
    function automatic int drain_cycles(input int dim);
        return 2 * dim - 1;
    endfunction

    localparam int DRAIN_CYCLES  = drain_cycles(ARRAY_DIM_DEF);
    localparam int OP_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/systolic_array_sequencer_if.sv
// Command, operand-buffer and PE-grid control signals of the sequencer.
// The slave modport is the sequencer's view; master is the command side.
interface systolic_array_sequencer_if
    import systolic_array_sequencer_pkg::*;
#(
    parameter int ARRAY_DIM = ARRAY_DIM_DEF,
    parameter int K_WIDTH   = K_WIDTH_DEF
);
    logic                 start;
    logic [K_WIDTH-1:0]   k_len;
    logic                 stall;
    logic                 op_rd_en;
    logic [K_WIDTH-1:0]   op_rd_addr;
    logic [ARRAY_DIM-1:0] row_valid;
    logic [ARRAY_DIM-1:0] col_valid;
    logic                 acc_clear;
    logic                 result_capture;
    logic                 busy;
    logic                 done;

    modport master (
        output start, k_len, stall,
        input  op_rd_en, op_rd_addr, row_valid, col_valid,
        input  acc_clear, result_capture, busy, done
    );

    modport slave (
        input  start, k_len, stall,
        output op_rd_en, op_rd_addr, row_valid, col_valid,
        output acc_clear, result_capture, busy, done
    );
endinterface

// File: rtl/systolic_array_sequencer_valid_skew_line.sv
// Shift line that turns the operand read strobe into DEPTH skewed valids:
// tap i is the read strobe delayed by LEAD + i cycles.
module valid_skew_line
    import systolic_array_sequencer_pkg::*;
#(
    parameter int DEPTH = ARRAY_DIM_DEF,
    parameter int LEAD  = OP_RD_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_serial,
    output logic [DEPTH-1:0] o_taps
);
    localparam int LEN = DEPTH + LEAD - 1;

    logic [LEN-1:0] r_chain;

    // Shifts every cycle, so a stalled read becomes a bubble moving through the grid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[LEN-2:0], i_serial};
        end
    end

    assign o_taps = r_chain[LEN-1:LEAD-1];

endmodule

// File: rtl/systolic_array_sequencer.sv
// Sequences one matrix-multiply pass: clear accumulators, feed K operand
// reads with skewed row/column valids, drain the wavefront, then signal done.
module systolic_array_sequencer
    import systolic_array_sequencer_pkg::*;
#(
    parameter int ARRAY_DIM = ARRAY_DIM_DEF,
    parameter int K_WIDTH   = K_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    systolic_array_sequencer_if.slave   bus
);
    localparam int DRAIN_LEN = drain_cycles(ARRAY_DIM);
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    seq_state_t         r_state;
    logic [K_WIDTH-1:0] r_k_len;
    logic [K_WIDTH-1:0] r_feed_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_acc_clear;
    logic               r_done;
    logic               r_busy;

    logic               w_rd_en;
    logic               w_last_rd;
    logic [ARRAY_DIM-1:0] w_row_taps;
    logic [ARRAY_DIM-1:0] w_col_taps;

    // NOTE: the read strobe reacts to stall in the same cycle, so it is decoded, not registered.
    assign w_rd_en   = (r_state == FEED) && !bus.stall;
    assign w_last_rd = (r_feed_cnt == r_k_len - 1'b1);

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_k_len     <= '0;
            r_feed_cnt  <= '0;
            r_drain_cnt <= '0;
            r_acc_clear <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_acc_clear <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_k_len     <= bus.k_len;
                        r_state     <= CLEAR;
                        r_acc_clear <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_feed_cnt <= '0;
                    if (r_k_len != '0) begin
                        r_state <= FEED;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                FEED: begin
                    if (w_rd_en) begin
                        r_feed_cnt <= r_feed_cnt + 1'b1;
                        if (w_last_rd) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= DRAIN_W'(DRAIN_LEN);
                        end
                    end
                end
                DRAIN: begin
                    r_drain_cnt <= r_drain_cnt - 1'b1;
                    if (r_drain_cnt == DRAIN_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    valid_skew_line #(.DEPTH(ARRAY_DIM), .LEAD(OP_RD_LATENCY)) u_row_skew (
        .clk      (clk),
        .reset    (reset),
        .i_serial (w_rd_en),
        .o_taps   (w_row_taps)
    );

    valid_skew_line #(.DEPTH(ARRAY_DIM), .LEAD(OP_RD_LATENCY)) u_col_skew (
        .clk      (clk),
        .reset    (reset),
        .i_serial (w_rd_en),
        .o_taps   (w_col_taps)
    );

    assign bus.op_rd_en       = w_rd_en;
    assign bus.op_rd_addr     = r_feed_cnt;
    assign bus.row_valid      = w_row_taps;
    assign bus.col_valid      = w_col_taps;
    assign bus.acc_clear      = r_acc_clear;
    assign bus.result_capture = r_done;
    assign bus.done           = r_done;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench for systolic_array_sequencer: directed passes push expected
// events into queues; a negedge monitor pops and compares each DUT event.
module tb_systolic_array_sequencer;
    localparam int N  = 4;
    localparam int KW = 8;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_err;

    exp_t clr_q[$];
    exp_t rd_q[$];
    exp_t vld_q[$];
    exp_t done_q[$];

    systolic_array_sequencer_if #(.ARRAY_DIM(N), .K_WIDTH(KW)) bus ();

    systolic_array_sequencer #(.ARRAY_DIM(N), .K_WIDTH(KW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input bit ok, input string got, input string exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s, expected %s", name, got, exp);
        end
    endtask

    // Expected events of one pass started in cycle t0; events at relative cycle >= cutoff are dropped.
    task automatic push_expect(input int t0, input int k, input int stall_rel,
                               input int done_rel, input int cutoff);
        bit rd_at [0:319];
        int c;
        exp_t e;
        e.cyc = t0 + 1; e.val = 0;
        clr_q.push_back(e);
        c = 2;
        for (int a = 0; a < k; a++) begin
            if (c == stall_rel) c++;
            if (c < cutoff) begin
                e.cyc = t0 + c; e.val = a;
                rd_q.push_back(e);
                rd_at[c] = 1'b1;
            end
            c++;
        end
        for (int r = 0; r < c + N + 2; r++) begin
            int v;
            v = 0;
            for (int i = 0; i < N; i++)
                if (r - 1 - i >= 0 && rd_at[r-1-i]) v |= (1 << i);
            if (v != 0 && r < cutoff) begin
                e.cyc = t0 + r; e.val = v;
                vld_q.push_back(e);
            end
        end
        if (done_rel >= 0) begin
            e.cyc = t0 + done_rel; e.val = 1;
            done_q.push_back(e);
        end
    endtask

    // Monitor: every visible DUT event must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.acc_clear) begin
            if (clr_q.size() == 0) begin
                check("acc_clear", 1'b0, $sformatf("pulse in cycle %0d", cyc), "no pulse");
            end else begin
                e = clr_q.pop_front();
                check("acc_clear", cyc == e.cyc && bus.busy == 1'b1,
                      $sformatf("cycle %0d busy %0b", cyc, bus.busy),
                      $sformatf("cycle %0d busy 1", e.cyc));
            end
        end
        if (bus.op_rd_en) begin
            if (rd_q.size() == 0) begin
                check("op_rd", 1'b0, $sformatf("read addr %0d in cycle %0d", bus.op_rd_addr, cyc), "no read");
            end else begin
                e = rd_q.pop_front();
                check("op_rd", cyc == e.cyc && int'(bus.op_rd_addr) == e.val,
                      $sformatf("addr %0d in cycle %0d", bus.op_rd_addr, cyc),
                      $sformatf("addr %0d in cycle %0d", e.val, e.cyc));
            end
        end
        if (bus.row_valid != '0 || bus.col_valid != '0) begin
            if (vld_q.size() == 0) begin
                check("skew_valid", 1'b0,
                      $sformatf("row %b col %b in cycle %0d", bus.row_valid, bus.col_valid, cyc), "no valids");
            end else begin
                e = vld_q.pop_front();
                check("skew_valid",
                      cyc == e.cyc && int'(bus.row_valid) == e.val && int'(bus.col_valid) == e.val,
                      $sformatf("row %b col %b in cycle %0d", bus.row_valid, bus.col_valid, cyc),
                      $sformatf("row %b col %b in cycle %0d", N'(e.val), N'(e.val), e.cyc));
            end
        end
        if (bus.done) begin
            if (done_q.size() == 0) begin
                check("done", 1'b0, $sformatf("pulse in cycle %0d", cyc), "no pulse");
            end else begin
                e = done_q.pop_front();
                check("done", cyc == e.cyc && bus.result_capture && bus.busy,
                      $sformatf("cycle %0d capture %0b busy %0b", cyc, bus.result_capture, bus.busy),
                      $sformatf("cycle %0d capture 1 busy 1", e.cyc));
            end
        end
        if (bus.done != bus.result_capture)
            check("capture_vs_done", 1'b0,
                  $sformatf("capture %0b done %0b", bus.result_capture, bus.done), "equal");
    end

    function automatic logic [31:0] all_outputs();
        return 32'({bus.op_rd_en, bus.op_rd_addr, bus.row_valid, bus.col_valid,
                    bus.acc_clear, bus.result_capture, bus.busy, bus.done});
    endfunction

    task automatic check_drained(input string name);
        check(name, clr_q.size() == 0 && rd_q.size() == 0 && vld_q.size() == 0 && done_q.size() == 0,
              $sformatf("pending clr %0d rd %0d vld %0d done %0d",
                        clr_q.size(), rd_q.size(), vld_q.size(), done_q.size()),
              "all queues empty");
    endtask

    // One pass; hold_until > 0 keeps start high that many cycles and expects a second pass.
    task automatic run_pass(input string name, input int k, input int stall_rel,
                            input int done_rel, input int hold_until, input int busy_pulse_rel);
        int t0;
        int end_rel;
        @(posedge clk); #1;
        t0 = cyc;
        push_expect(t0, k, stall_rel, done_rel, 1 << 20);
        if (hold_until > 0) push_expect(t0 + hold_until, k, stall_rel, done_rel, 1 << 20);
        end_rel = (hold_until > 0) ? hold_until + done_rel + 1 : done_rel + 1;
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        bus.stall = 1'b0;
        for (int rel = 1; rel <= end_rel; rel++) begin
            @(posedge clk); #1;
            bus.start = (rel <= hold_until) || (rel == busy_pulse_rel);
            bus.k_len = (rel <= hold_until) ? KW'(k) : 8'hA5;
            bus.stall = (rel == stall_rel);
        end
        @(negedge clk);
        check({name, "_idle"}, bus.busy == 1'b0, $sformatf("busy %0b", bus.busy), "busy 0");
        check_drained({name, "_drained"});
        bus.stall = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        n_checks = 0;
        n_err    = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", all_outputs() == '0, $sformatf("outputs %h", all_outputs()), "all zero");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // k=3: clear c1, reads c2-4, valids c3-8, done c12; stray start in c5 ignored
        run_pass("basic", 3, -1, 12, 0, 5);
        // stall in c3: reads c2,c4,c5, done c13
        run_pass("stall", 3, 3, 13, 0, -1);
        // k=0: clear c1, done c2, no reads or valids
        run_pass("k_zero", 0, -1, 2, 0, -1);
        // start held: done c10, second start accepted in c11, second done c21
        run_pass("held_start", 1, -1, 10, 11, -1);

        // reset asserted in cycle 6 aborts the pass with no done
        @(posedge clk); #1;
        t0 = cyc;
        push_expect(t0, 3, -1, -1, 6);
        bus.start = 1'b1;
        bus.k_len = 8'd3;
        for (int rel = 1; rel <= 6; rel++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.k_len = 8'h5A;
        end
        reset = 1'b0;
        #1;
        check("async_reset", all_outputs() == '0, $sformatf("outputs %h", all_outputs()), "all zero");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_idle", bus.busy == 1'b0, $sformatf("busy %0b", bus.busy), "busy 0");
        check_drained("abort_drained");

        // normal pass after the abort: done c11
        run_pass("after_reset", 2, -1, 11, 0, -1);
        // full-range K: addresses 0..254, done c264
        run_pass("k_max", 255, -1, 264, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
